// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, state/status encodings and frame build/check helpers.
// Frames are 11 bits: start(0), 8 data bits LSB-first, odd parity, stop(1).
package ps2_pkg;

  localparam logic [7:0]  PS2_ACK        = 8'hFA;
  localparam logic [7:0]  PS2_RESEND     = 8'hFE;
  localparam logic [10:0] PS2_IDLE_FRAME = 11'h7FF;

  typedef enum logic [1:0] {
    STAT_OK        = 2'b00,
    STAT_NAK       = 2'b01,
    STAT_TIMEOUT   = 2'b10,
    STAT_FRAME_ERR = 2'b11
  } ps2_status_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } ps2_state_e;

  function automatic logic [10:0] ps2_make_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  // Odd parity means data plus parity bit carry an odd number of ones.
  function automatic logic ps2_frame_ok(input logic [10:0] f);
    return (~f[0]) & f[10] & (^f[9:1]);
  endfunction

endpackage

// File: rtl/ps2_cmd_sequencer_if.sv
// Command, transmit-frame and receive-frame signals between the IPIF side,
// the PS/2 core datapath and the command sequencer.
interface ps2_cmd_sequencer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_byte;
  logic        cmd_has_arg;
  logic [7:0]  cmd_arg;
  logic [10:0] tx_frame;
  logic        tx_valid;
  logic        tx_ready;
  logic [10:0] rx_frame;
  logic        rx_valid;
  logic        done;
  logic [1:0]  status;
  logic [7:0]  resp_byte;
  logic        busy;

  // Environment side: issues commands, accepts frames, supplies replies.
  modport master (
    output cmd_valid, cmd_byte, cmd_has_arg, cmd_arg, tx_ready, rx_frame, rx_valid,
    input  cmd_ready, tx_frame, tx_valid, done, status, resp_byte, busy
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_byte, cmd_has_arg, cmd_arg, tx_ready, rx_frame, rx_valid,
    output cmd_ready, tx_frame, tx_valid, done, status, resp_byte, busy
  );

endinterface

// File: rtl/ps2_timeout.sv
// Clear/enable cycle counter with a registered one-cycle pulse on terminal
// count; shared by the command sequencer and the receiver watchdog.
module ps2_timeout #(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int CNT_W          = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             at_tc;

  assign at_tc = (cnt_q == TC_VAL);

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_tc ? '0 : cnt_q + 1'b1;
      tc_d  = at_tc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// Issues a one- or two-byte PS/2 device command as framed bytes and tracks the
// device reply: ACK advances/finishes, RESEND retries, anything else ends it.
module ps2_cmd_sequencer
  import ps2_pkg::*;
#(
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int CNT_W          = 21
) (
  input  logic            Bus2IP_Clk,
  input  logic            Bus2IP_Reset,
  ps2_cmd_sequencer_if.slave bus
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_SEND = ST_SEND;
  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_DONE = ST_DONE;

  localparam logic PH_CMD = 1'b0;
  localparam logic PH_ARG = 1'b1;

  logic [1:0]    state_q, state_d;
  logic          phase_q, phase_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    arg_q, arg_d;
  logic          has_arg_q, has_arg_d;
  logic [10:0]   tx_frame_q, tx_frame_d;
  logic [1:0]    status_q, status_d;
  logic [7:0]    resp_q, resp_d;

  logic          tmo_clr, tmo_en, tmo_tc;
  logic [7:0]    rx_data;
  logic          rx_ok;

  assign rx_data = bus.rx_frame[8:1];
  assign rx_ok   = ps2_frame_ok(bus.rx_frame);
  assign tmo_en  = (state_q == S_WAIT);

  ps2_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_tmo (
    .clk   (Bus2IP_Clk),
    .rst   (Bus2IP_Reset),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .tc_o  (tmo_tc)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    retry_d    = retry_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    has_arg_d  = has_arg_q;
    tx_frame_d = tx_frame_q;
    status_d   = status_q;
    resp_d     = resp_q;
    tmo_clr    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d      = bus.cmd_byte;
          arg_d      = bus.cmd_arg;
          has_arg_d  = bus.cmd_has_arg;
          phase_d    = PH_CMD;
          retry_d    = '0;
          tx_frame_d = ps2_make_frame(bus.cmd_byte);
          state_d    = S_SEND;
        end
      end

      S_SEND: begin
        if (bus.tx_ready) begin
          tmo_clr    = 1'b1;
          tx_frame_d = PS2_IDLE_FRAME;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        // A reply landing on the terminal-count cycle takes priority.
        if (bus.rx_valid) begin
          resp_d = rx_data;
          if (!rx_ok) begin
            status_d = STAT_FRAME_ERR;
            state_d  = S_DONE;
          end else if (rx_data == PS2_ACK) begin
            if (phase_q == PH_CMD && has_arg_q) begin
              phase_d    = PH_ARG;
              retry_d    = '0;
              tx_frame_d = ps2_make_frame(arg_q);
              state_d    = S_SEND;
            end else begin
              status_d = STAT_OK;
              state_d  = S_DONE;
            end
          end else if (rx_data == PS2_RESEND) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_d    = retry_q + 1'b1;
              tx_frame_d = ps2_make_frame((phase_q == PH_ARG) ? arg_q : cmd_q);
              state_d    = S_SEND;
            end else begin
              status_d = STAT_NAK;
              state_d  = S_DONE;
            end
          end else begin
            status_d = STAT_NAK;
            state_d  = S_DONE;
          end
        end else if (tmo_tc) begin
          status_d = STAT_TIMEOUT;
          state_d  = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_CMD;
      retry_q    <= '0;
      cmd_q      <= '0;
      arg_q      <= '0;
      has_arg_q  <= 1'b0;
      tx_frame_q <= PS2_IDLE_FRAME;
      status_q   <= STAT_OK;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      retry_q    <= retry_d;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      has_arg_q  <= has_arg_d;
      tx_frame_q <= tx_frame_d;
      status_q   <= status_d;
      resp_q     <= resp_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.tx_valid  = (state_q == S_SEND);
  assign bus.done      = (state_q == S_DONE);
  assign bus.tx_frame  = tx_frame_q;
  assign bus.status    = status_q;
  assign bus.resp_byte = resp_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed scenarios for the PS/2 command sequencer with a short timeout.
module tb_ps2_cmd_sequencer;

  localparam int TMO = 100;
  localparam int MAXW = 500;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   hs_cnt = 0;
  int   done_cnt = 0;
  bit   watch_busy = 0;
  bit   busy_drop = 0;

  ps2_cmd_sequencer_if bus();

  ps2_cmd_sequencer #(
    .MAX_RETRY      (3),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (7)
  ) dut (
    .Bus2IP_Clk   (clk),
    .Bus2IP_Reset (rst),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus.tx_valid && bus.tx_ready) hs_cnt++;
    if (!rst && bus.done) done_cnt++;
  end

  always @(negedge clk) if (watch_busy && !bus.busy) busy_drop = 1;

  // Stimulus helpers (no checking inside).
  task automatic issue(input logic [7:0] c, input logic ha, input logic [7:0] a);
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < MAXW) begin @(negedge clk); n++; end
    bus.cmd_valid = 1; bus.cmd_byte = c; bus.cmd_has_arg = ha; bus.cmd_arg = a;
    @(posedge clk); #1;
    bus.cmd_valid = 0;
  endtask

  task automatic take_tx(input int hold, output logic [10:0] f0, output logic [10:0] f1, output int n);
    n = 0;
    @(negedge clk);
    while (!bus.tx_valid && n < MAXW) begin @(negedge clk); n++; end
    f0 = bus.tx_frame;
    repeat (hold) @(negedge clk);
    f1 = bus.tx_valid ? bus.tx_frame : 11'h000;
    bus.tx_ready = 1;
    @(posedge clk); #1;
    bus.tx_ready = 0;
  endtask

  task automatic send_rx(input logic [10:0] f);
    @(negedge clk);
    bus.rx_valid = 1; bus.rx_frame = f;
    @(posedge clk); #1;
    bus.rx_valid = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    @(negedge clk);
    while (!bus.done && n < MAXW) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
    total++; if (bus.tx_frame !== 11'h7FF) begin bad++; $display("FAIL reset_tx_frame got=%h exp=7ff", bus.tx_frame); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.status !== 2'b00) begin bad++; $display("FAIL reset_status got=%b exp=00", bus.status); end
    total++; if (bus.resp_byte !== 8'h00) begin bad++; $display("FAIL reset_resp got=%h exp=00", bus.resp_byte); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    rst = 0;
  endtask

  task automatic test_single();
    logic [10:0] f0, f1; int n;
    hs_cnt = 0;
    issue(8'hF4, 1'b0, 8'h00);
    take_tx(0, f0, f1, n);
    total++; if (n !== 0) begin bad++; $display("FAIL single_tx_latency got=%0d exp=0", n); end
    total++; if (f0 !== 11'h5E8) begin bad++; $display("FAIL single_frame got=%h exp=5e8", f0); end
    send_rx(11'h7F4);
    wait_done(n);
    total++; if (n !== 0) begin bad++; $display("FAIL single_done_latency got=%0d exp=0", n); end
    total++; if (bus.status !== 2'b00) begin bad++; $display("FAIL single_status got=%b exp=00", bus.status); end
    total++; if (bus.resp_byte !== 8'hFA) begin bad++; $display("FAIL single_resp got=%h exp=fa", bus.resp_byte); end
    total++; if (hs_cnt !== 1) begin bad++; $display("FAIL single_hs got=%0d exp=1", hs_cnt); end
  endtask

  task automatic test_two_byte();
    logic [10:0] f0, f1; int n;
    hs_cnt = 0; busy_drop = 0;
    issue(8'hED, 1'b1, 8'h02);
    watch_busy = 1;
    take_tx(3, f0, f1, n);
    total++; if (f0 !== 11'h7DA) begin bad++; $display("FAIL two_frame0 got=%h exp=7da", f0); end
    total++; if (f1 !== 11'h7DA) begin bad++; $display("FAIL two_frame0_held got=%h exp=7da", f1); end
    send_rx(11'h7F4);
    take_tx(0, f0, f1, n);
    total++; if (f0 !== 11'h404) begin bad++; $display("FAIL two_frame1 got=%h exp=404", f0); end
    send_rx(11'h7F4);
    wait_done(n);
    watch_busy = 0;
    total++; if (n !== 0 || bus.status !== 2'b00) begin bad++; $display("FAIL two_status got=%b exp=00 wait=%0d", bus.status, n); end
    total++; if (hs_cnt !== 2) begin bad++; $display("FAIL two_hs got=%0d exp=2", hs_cnt); end
    total++; if (busy_drop) begin bad++; $display("FAIL two_busy got=dropped exp=held"); end
  endtask

  task automatic test_resend();
    logic [10:0] f0, f1; int n;
    hs_cnt = 0;
    issue(8'hFF, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      take_tx(0, f0, f1, n);
      total++; if (f0 !== 11'h7FE) begin bad++; $display("FAIL resend_frame%0d got=%h exp=7fe", i, f0); end
      send_rx((i < 2) ? 11'h5FC : 11'h7F4);
    end
    wait_done(n);
    total++; if (n !== 0 || bus.status !== 2'b00) begin bad++; $display("FAIL resend_status got=%b exp=00 wait=%0d", bus.status, n); end
    total++; if (hs_cnt !== 3) begin bad++; $display("FAIL resend_hs got=%0d exp=3", hs_cnt); end
  endtask

  task automatic test_resend_exhaust();
    logic [10:0] f0, f1; int n;
    hs_cnt = 0;
    issue(8'hFF, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      take_tx(0, f0, f1, n);
      send_rx(11'h5FC);
    end
    wait_done(n);
    total++; if (n !== 0 || bus.status !== 2'b01) begin bad++; $display("FAIL exhaust_status got=%b exp=01 wait=%0d", bus.status, n); end
    total++; if (hs_cnt !== 4) begin bad++; $display("FAIL exhaust_hs got=%0d exp=4", hs_cnt); end
    total++; if (bus.resp_byte !== 8'hFE) begin bad++; $display("FAIL exhaust_resp got=%h exp=fe", bus.resp_byte); end
  endtask

  task automatic test_timeout();
    logic [10:0] f0, f1; int n; int cyc = 0;
    issue(8'hF4, 1'b0, 8'h00);
    take_tx(0, f0, f1, n);
    while (cyc < 300) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (bus.done) break;
    end
    total++; if (cyc !== TMO + 1) begin bad++; $display("FAIL timeout_cycles got=%0d exp=%0d", cyc, TMO + 1); end
    total++; if (bus.status !== 2'b10) begin bad++; $display("FAIL timeout_status got=%b exp=10", bus.status); end
  endtask

  task automatic test_timeout_race();
    logic [10:0] f0, f1; int n; int d0;
    issue(8'hF4, 1'b0, 8'h00);
    take_tx(0, f0, f1, n);
    d0 = done_cnt;
    repeat (TMO) @(posedge clk);
    send_rx(11'h7F4);
    @(negedge clk);
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL race_early_done got=%0d exp=%0d", done_cnt, d0); end
    total++; if (bus.done !== 1'b1 || bus.status !== 2'b00) begin bad++; $display("FAIL race_status got=%b/%b exp=1/00", bus.done, bus.status); end
  endtask

  task automatic test_malformed();
    logic [10:0] f0, f1; int n;
    issue(8'hF4, 1'b0, 8'h00);
    take_tx(0, f0, f1, n);
    send_rx(11'h5F4);
    wait_done(n);
    total++; if (n !== 0 || bus.status !== 2'b11) begin bad++; $display("FAIL malformed_status got=%b exp=11 wait=%0d", bus.status, n); end
    total++; if (bus.resp_byte !== 8'hFA) begin bad++; $display("FAIL malformed_resp got=%h exp=fa", bus.resp_byte); end
    issue(8'hF4, 1'b0, 8'h00);
    take_tx(0, f0, f1, n);
    send_rx(11'h7F8);
    wait_done(n);
    total++; if (n !== 0 || bus.status !== 2'b01) begin bad++; $display("FAIL nak_status got=%b exp=01 wait=%0d", bus.status, n); end
    total++; if (bus.resp_byte !== 8'hFC) begin bad++; $display("FAIL nak_resp got=%h exp=fc", bus.resp_byte); end
  endtask

  task automatic test_reset_mid();
    logic [10:0] f0, f1; int n; int d0;
    issue(8'hF4, 1'b0, 8'h00);
    take_tx(0, f0, f1, n);
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    rst = 1; #1;
    total++; if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      bad++; $display("FAIL midreset_outputs got=%b%b%b exp=001", bus.tx_valid, bus.busy, bus.cmd_ready); end
    total++; if (bus.status !== 2'b00 || bus.resp_byte !== 8'h00) begin
      bad++; $display("FAIL midreset_regs got=%b/%h exp=00/00", bus.status, bus.resp_byte); end
    @(negedge clk); rst = 0;
    repeat (5) @(negedge clk);
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL midreset_done got=%0d exp=%0d", done_cnt, d0); end
    issue(8'hF4, 1'b0, 8'h00);
    take_tx(0, f0, f1, n);
    total++; if (f0 !== 11'h5E8) begin bad++; $display("FAIL after_reset_frame got=%h exp=5e8", f0); end
    send_rx(11'h7F4);
    wait_done(n);
    total++; if (n !== 0 || bus.status !== 2'b00) begin bad++; $display("FAIL after_reset_status got=%b exp=00 wait=%0d", bus.status, n); end
  endtask

  initial begin
    rst = 1;
    bus.cmd_valid = 0; bus.cmd_byte = 0; bus.cmd_has_arg = 0; bus.cmd_arg = 0;
    bus.tx_ready = 0; bus.rx_frame = 11'h7FF; bus.rx_valid = 0;
    test_reset();
    test_single();
    test_two_byte();
    test_resend();
    test_resend_exhaust();
    test_timeout();
    test_timeout_race();
    test_malformed();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
